// File: rtl/route_compute_unit.sv
// Per-input-port dimension-order route stage: a head accepted at edge N is routed and locked from cycle N+1.
// The route is held until release_i; head_ready_o drops while locked unless release_i frees the port in the same cycle.
module route_compute_unit #(
    parameter int NOC_WIDTH    = 4,
    parameter int NOC_LENGTH   = 4,
    parameter int ROUTER_ID    = 0,
    parameter int ROUTING_MODE = 0,
    parameter int CNT_W        = 16,
    localparam int X_W         = $clog2(NOC_WIDTH),
    localparam int Y_W         = $clog2(NOC_LENGTH),
    localparam int ADDR_W      = X_W + Y_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              head_valid_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    output logic              head_ready_o,
    input  logic              release_i,
    output logic              route_valid_o,
    output logic [2:0]        route_port_o,
    output logic [4:0]        route_oh_o,
    output logic              addr_err_o,
    output logic              proto_err_o,
    output logic [CNT_W-1:0]  pkt_count_o,
    input  logic              clr_i
);
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [ADDR_W-1:0] RID   = ADDR_W'(ROUTER_ID);
    localparam logic [X_W-1:0]    RX    = RID[X_W-1:0];
    localparam logic [Y_W-1:0]    RY    = RID[ADDR_W-1:X_W];
    localparam logic [X_W:0]      X_LIM = (X_W+1)'(NOC_WIDTH);
    localparam logic [Y_W:0]      Y_LIM = (Y_W+1)'(NOC_LENGTH);

    logic [0:0]       r_state;
    logic [2:0]       r_port;
    logic [4:0]       r_oh;
    logic             r_addr_err;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_cnt;

    logic [X_W-1:0]   w_dx;
    logic [Y_W-1:0]   w_dy;
    logic             w_oor;
    logic             w_accept;
    logic             w_idle_release;
    logic [2:0]       w_port;

    assign w_dx           = dest_addr_i[X_W-1:0];
    assign w_dy           = dest_addr_i[ADDR_W-1:X_W];
    assign w_oor          = ({1'b0, w_dx} >= X_LIM) || ({1'b0, w_dy} >= Y_LIM);
    assign head_ready_o   = (r_state == ST_IDLE) || release_i;
    assign w_accept       = head_valid_i && head_ready_o;
    assign w_idle_release = (r_state == ST_IDLE) && release_i;

    // Out-of-mesh destinations are steered to LOCAL so the packet still drains.
    always_comb begin
        w_port = PORT_LOCAL;
        if (w_oor || (dest_addr_i == RID)) begin
            w_port = PORT_LOCAL;
        end else if (ROUTING_MODE == 1) begin
            if (w_dy != RY)      w_port = (w_dy < RY) ? PORT_NORTH : PORT_SOUTH;
            else                 w_port = (w_dx > RX) ? PORT_EAST  : PORT_WEST;
        end else begin
            if (w_dx != RX)      w_port = (w_dx > RX) ? PORT_EAST  : PORT_WEST;
            else                 w_port = (w_dy < RY) ? PORT_NORTH : PORT_SOUTH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_port  <= 3'd0;
            r_oh    <= 5'd0;
        end else if (w_accept) begin
            r_state <= ST_ACTIVE;
            r_port  <= w_port;
            r_oh    <= 5'(1) << w_port;
        end else if ((r_state == ST_ACTIVE) && release_i) begin
            r_state <= ST_IDLE;
            r_port  <= 3'd0;
            r_oh    <= 5'd0;
        end
    end

    // Clear wins over any same-cycle error set or count increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err  <= 1'b0;
            r_proto_err <= 1'b0;
            r_cnt       <= '0;
        end else if (clr_i) begin
            r_addr_err  <= 1'b0;
            r_proto_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept && w_oor) r_addr_err  <= 1'b1;
            if (w_idle_release)    r_proto_err <= 1'b1;
            if (w_accept && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign route_valid_o = (r_state == ST_ACTIVE);
    assign route_port_o  = r_port;
    assign route_oh_o    = r_oh;
    assign addr_err_o    = r_addr_err;
    assign proto_err_o   = r_proto_err;
    assign pkt_count_o   = r_cnt;

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: three configurations driven with shared stimulus, checked against a reference model.
module tb_route_compute_unit;
    localparam int LOCAL = 0, NORTH = 1, SOUTH = 2, EAST = 3, WEST = 4;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic head_valid = 1'b0;
    logic [3:0] dest = 4'd0;
    logic rel = 1'b0;
    logic clr = 1'b0;

    logic        rdy[N], vld[N], aerr[N], perr[N];
    logic [2:0]  port[N];
    logic [4:0]  oh[N];
    logic [15:0] cnt[N];
    logic [1:0]  cnt_w3;
    assign cnt[2] = {14'd0, cnt_w3};

    // Model configuration per instance: 0 = 4x4 XY, 1 = 4x4 YX, 2 = 3x4 XY with 2-bit counter.
    int cfg_w[N]    = '{4, 4, 3};
    int cfg_l[N]    = '{4, 4, 4};
    int cfg_yx[N]   = '{0, 1, 0};
    int cfg_cmax[N] = '{65535, 65535, 3};

    int m_act[N], m_port[N], m_aerr[N], m_perr[N], m_cnt[N];
    bit rdy_pre[N];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .ROUTING_MODE(0), .CNT_W(16)) u_xy (
        .clk(clk), .rst_n(rst_n), .head_valid_i(head_valid), .dest_addr_i(dest), .head_ready_o(rdy[0]),
        .release_i(rel), .route_valid_o(vld[0]), .route_port_o(port[0]), .route_oh_o(oh[0]),
        .addr_err_o(aerr[0]), .proto_err_o(perr[0]), .pkt_count_o(cnt[0]), .clr_i(clr));
    route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .ROUTING_MODE(1), .CNT_W(16)) u_yx (
        .clk(clk), .rst_n(rst_n), .head_valid_i(head_valid), .dest_addr_i(dest), .head_ready_o(rdy[1]),
        .release_i(rel), .route_valid_o(vld[1]), .route_port_o(port[1]), .route_oh_o(oh[1]),
        .addr_err_o(aerr[1]), .proto_err_o(perr[1]), .pkt_count_o(cnt[1]), .clr_i(clr));
    route_compute_unit #(.NOC_WIDTH(3), .NOC_LENGTH(4), .ROUTER_ID(5), .ROUTING_MODE(0), .CNT_W(2)) u_w3 (
        .clk(clk), .rst_n(rst_n), .head_valid_i(head_valid), .dest_addr_i(dest), .head_ready_o(rdy[2]),
        .release_i(rel), .route_valid_o(vld[2]), .route_port_o(port[2]), .route_oh_o(oh[2]),
        .addr_err_o(aerr[2]), .proto_err_o(perr[2]), .pkt_count_o(cnt_w3), .clr_i(clr));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dimension-order routing from mesh coordinates (router sits at x=1, y=1).
    function automatic int ref_route(input int i, input int d);
        int dx = d % 4;
        int dy = d / 4;
        if (dx >= cfg_w[i] || dy >= cfg_l[i] || (dx == 1 && dy == 1)) return LOCAL;
        if (cfg_yx[i] != 0) begin
            if (dy != 1) return (dy < 1) ? NORTH : SOUTH;
            return (dx > 1) ? EAST : WEST;
        end
        if (dx != 1) return (dx > 1) ? EAST : WEST;
        return (dy < 1) ? NORTH : SOUTH;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_port[i] = 0; m_aerr[i] = 0; m_perr[i] = 0; m_cnt[i] = 0;
        end
    endfunction

    function automatic void model_edge(input bit hv, input int d, input bit r, input bit c);
        for (int i = 0; i < N; i++) begin
            bit acc = hv && (m_act[i] == 0 || r);
            bit oor = ((d % 4) >= cfg_w[i]) || ((d / 4) >= cfg_l[i]);
            if (m_act[i] == 0 && r) m_perr[i] = 1;
            if (acc) begin
                m_act[i] = 1;
                m_port[i] = ref_route(i, d);
                if (oor) m_aerr[i] = 1;
                if (m_cnt[i] < cfg_cmax[i]) m_cnt[i]++;
            end else if (r) begin
                m_act[i] = 0;
            end
            if (c) begin
                m_aerr[i] = 0; m_perr[i] = 0; m_cnt[i] = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s[%0d].route_valid", tag, i), int'(vld[i]), m_act[i]);
            chk($sformatf("%s[%0d].route_oh", tag, i), int'(oh[i]), (m_act[i] != 0) ? (1 << m_port[i]) : 0);
            if (m_act[i] != 0) chk($sformatf("%s[%0d].route_port", tag, i), int'(port[i]), m_port[i]);
            chk($sformatf("%s[%0d].addr_err", tag, i), int'(aerr[i]), m_aerr[i]);
            chk($sformatf("%s[%0d].proto_err", tag, i), int'(perr[i]), m_perr[i]);
            chk($sformatf("%s[%0d].pkt_count", tag, i), int'(cnt[i]), m_cnt[i]);
        end
    endtask

    // Called just after a falling edge: drive, check the combinational ready, clock, then check registers.
    task automatic cycle(input bit hv, input int d, input bit r, input bit c, input string tag);
        head_valid = hv; dest = 4'(d); rel = r; clr = c;
        #1;
        for (int i = 0; i < N; i++) begin
            rdy_pre[i] = rdy[i];
            chk($sformatf("%s[%0d].head_ready", tag, i), int'(rdy[i]), (m_act[i] == 0 || r) ? 1 : 0);
        end
        @(posedge clk);
        model_edge(hv, d, r, c);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; head_valid = 1'b0; rel = 1'b0; clr = 1'b0; dest = 4'd0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        #1;
        check_outputs("reset");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset[%0d].route_port", i), int'(port[i]), 0);
            chk($sformatf("reset[%0d].head_ready", i), int'(rdy[i]), 1);
        end
    endtask

    typedef struct {
        bit hv; int d; bit r; bit c;
        bit e_rdy; bit e_vld; int e_port; int e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Expectations for the 4x4 XY router at ROUTER_ID=5.
        tbl[0]  = '{1, 7,  0, 0, 1, 1, EAST,  1};
        tbl[1]  = '{0, 0,  0, 0, 0, 1, EAST,  1};
        tbl[2]  = '{1, 4,  1, 0, 1, 1, WEST,  2};
        tbl[3]  = '{0, 0,  1, 0, 1, 0, 0,     2};
        tbl[4]  = '{1, 14, 0, 0, 1, 1, EAST,  3};
        tbl[5]  = '{0, 0,  1, 0, 1, 0, 0,     3};
        tbl[6]  = '{1, 5,  0, 0, 1, 1, LOCAL, 4};
        tbl[7]  = '{1, 13, 1, 0, 1, 1, SOUTH, 5};
        tbl[8]  = '{1, 1,  1, 0, 1, 1, NORTH, 6};
        tbl[9]  = '{0, 0,  1, 0, 1, 0, 0,     6};
        tbl[10] = '{0, 0,  0, 1, 1, 0, 0,     0};

        do_reset();
        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].hv, tbl[k].d, tbl[k].r, tbl[k].c, $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d.ready", k), int'(rdy_pre[0]), int'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d.valid", k), int'(vld[0]), int'(tbl[k].e_vld));
            if (tbl[k].e_vld) chk($sformatf("tbl%0d.port", k), int'(port[0]), tbl[k].e_port);
            chk($sformatf("tbl%0d.count", k), int'(cnt[0]), tbl[k].e_cnt);
        end

        // Same destination, different algorithms.
        do_reset();
        cycle(1, 14, 0, 0, "mode");
        chk("mode.yx_south", int'(port[1]), SOUTH);
        chk("mode.xy_east", int'(port[0]), EAST);

        // Locked route ignores heads until release.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 2, 0, 0, "hold");
            chk("hold.ready", int'(rdy_pre[0]), 0);
            chk("hold.port", int'(port[0]), EAST);
            chk("hold.count", int'(cnt[0]), 1);
        end

        // Out-of-range x on the 3-wide mesh, then release while idle, then clear.
        do_reset();
        cycle(1, 7, 0, 0, "oor");
        chk("oor.w3_local", int'(port[2]), LOCAL);
        chk("oor.w3_addr_err", int'(aerr[2]), 1);
        chk("oor.xy_addr_err", int'(aerr[0]), 0);
        cycle(0, 0, 1, 0, "rel");
        cycle(0, 0, 1, 0, "idle_rel");
        chk("idle_rel.proto_err", int'(perr[0]), 1);
        cycle(0, 0, 0, 1, "clr");
        chk("clr.addr_err", int'(aerr[2]), 0);
        chk("clr.proto_err", int'(perr[0]), 0);
        chk("clr.count", int'(cnt[0]), 0);

        // Saturation of the 2-bit counter, then asynchronous reset mid-packet.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 7, 1, 0, "sat");
        chk("sat.cnt2", int'(cnt[2]), 3);
        chk("sat.cnt16", int'(cnt[0]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("arst[%0d].valid", i), int'(vld[i]), 0);
            chk($sformatf("arst[%0d].oh", i), int'(oh[i]), 0);
            chk($sformatf("arst[%0d].count", i), int'(cnt[i]), 0);
        end
        @(negedge clk);
        do_reset();

        // Random traffic against the model on all three configurations.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 29) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
